// File: rtl/stopwatch_pkg.sv
// Shared definitions for the lab stopwatch controller.
// Holds the FSM state encodings and the BCD digit limits used by the
// time counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_e;

  // Largest value of a seconds-ones / minutes-ones digit.
  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  // Largest value of the seconds-tens digit.
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit BCD MM:SS counter.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset, clears all digits
//   clr    - synchronous clear, takes priority over inc
//   inc    - advance the count by one second
//   count  - {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
// The count wraps to 00:00 after MAX_MIN_TENS9:59.
module bcd_mmss_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN_TENS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  localparam logic [3:0] MinTensMax = 4'(MAX_MIN_TENS);

  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;

  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    if (clr) begin
      sec_ones_d = '0;
      sec_tens_d = '0;
      min_ones_d = '0;
      min_tens_d = '0;
    end else if (inc) begin
      if (sec_ones_q == BCD_MAX_ONES) begin
        sec_ones_d = '0;
        if (sec_tens_q == BCD_MAX_SEC_TENS) begin
          sec_tens_d = '0;
          if (min_ones_q == BCD_MAX_ONES) begin
            min_ones_d = '0;
            min_tens_d = (min_tens_q == MinTensMax) ? 4'd0 : min_tens_q + 4'd1;
          end else begin
            min_ones_d = min_ones_q + 4'd1;
          end
        end else begin
          sec_tens_d = sec_tens_q + 4'd1;
        end
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec_ones_q <= '0;
      sec_tens_q <= '0;
      min_ones_q <= '0;
      min_tens_q <= '0;
    end else begin
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
    end
  end

  assign count = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller.
// Turns the debounced start/stop and lap/reset button levels into press
// events, runs the IDLE/RUN/PAUSE/LAP FSM, gates the BCD time counter and
// selects the lap snapshot or the live count for the display.
// Ports:
//   clk, rst_n         - clock and synchronous active-low reset
//   tick               - 1 Hz single-cycle enable
//   btn_ss, btn_lr     - debounced button levels, active high
//   state              - current FSM state
//   count_en           - counter advances on tick while high
//   sec_ones..min_tens - displayed BCD digits (registered sources only)
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN_TENS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic [1:0] state,
  output logic       count_en,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens
);

  sw_state_e   state_q, state_d;
  logic        prev_ss_q, prev_lr_q;
  logic [15:0] lap_q, lap_d;
  logic [15:0] live;
  logic [15:0] disp;
  logic        ss_press, lr_press;
  logic        clr;

  // Previous levels reset high so a button held through reset is not a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_ss_q <= 1'b1;
      prev_lr_q <= 1'b1;
    end else begin
      prev_ss_q <= btn_ss;
      prev_lr_q <= btn_lr;
    end
  end

  assign ss_press = btn_ss & ~prev_ss_q;
  assign lr_press = btn_lr & ~prev_lr_q;

  // Start/stop has priority; a coincident lap/reset press is dropped.
  always_comb begin
    state_d = state_q;
    if (ss_press) begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        ST_LAP:   state_d = ST_PAUSE;
        default:  state_d = ST_IDLE;
      endcase
    end else if (lr_press) begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_RUN:   state_d = ST_LAP;
        ST_PAUSE: state_d = ST_IDLE;
        ST_LAP:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign count_en = (state_q == ST_RUN) | (state_q == ST_LAP);
  assign clr      = (state_d == ST_IDLE) & (state_q != ST_IDLE);

  bcd_mmss_counter #(
    .MAX_MIN_TENS(MAX_MIN_TENS)
  ) u_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (tick & count_en),
    .count(live)
  );

  // Snapshot is the pre-edge live value, so a same-edge tick is not included.
  always_comb begin
    lap_d = lap_q;
    if (clr) begin
      lap_d = '0;
    end else if ((state_q == ST_RUN) && (state_d == ST_LAP)) begin
      lap_d = live;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign disp  = (state_q == ST_LAP) ? lap_q : live;
  assign state = state_q;
  assign {min_tens, min_ones, sec_tens, sec_ones} = disp;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios followed by
// randomized buttons/ticks/resets, all compared every cycle against a
// model that keeps time as a plain seconds count.
module tb_stopwatch_ctrl;

  localparam int unsigned MaxMinTens = 5;
  localparam int Period = (MaxMinTens * 10 + 10) * 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic [1:0] state;
  logic       count_en;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;

  int checks = 0;
  int failures = 0;

  // Model: state by its encoded number, time in whole seconds.
  int m_state = 0;
  int m_live = 0;
  int m_lap = 0;
  bit m_pss = 1'b1;
  bit m_plr = 1'b1;

  stopwatch_ctrl #(
    .MAX_MIN_TENS(MaxMinTens)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .btn_ss  (btn_ss),
    .btn_lr  (btn_lr),
    .state   (state),
    .count_en(count_en),
    .sec_ones(sec_ones),
    .sec_tens(sec_tens),
    .min_ones(min_ones),
    .min_tens(min_tens)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_digits(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return 32'((m / 10) << 12 | (m % 10) << 8 | (s / 10) << 4 | (s % 10));
  endfunction

  function automatic logic [31:0] dut_digits();
    return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit r, input bit ss, input bit lr, input bit tk);
    bit ssp, lrp;
    int ns;
    rst_n  = ~r;
    btn_ss = ss;
    btn_lr = lr;
    tick   = tk;
    if (r) begin
      m_state = 0; m_live = 0; m_lap = 0; m_pss = 1'b1; m_plr = 1'b1;
    end else begin
      ssp = ss & ~m_pss;
      lrp = lr & ~m_plr;
      ns = m_state;
      if (ssp) ns = (m_state == 1) ? 2 : (m_state == 3) ? 2 : 1;
      else if (lrp) ns = (m_state == 1) ? 3 : (m_state == 3) ? 1 : 0;
      if (m_state == 1 && ns == 3) m_lap = m_live;
      if ((m_state == 1 || m_state == 3) && tk) m_live = (m_live + 1) % Period;
      if (ns == 0 && m_state != 0) begin
        m_live = 0;
        m_lap = 0;
      end
      m_state = ns;
      m_pss = ss;
      m_plr = lr;
    end
    @(posedge clk);
    #1;
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("count_en", 32'(count_en), 32'((m_state == 1 || m_state == 3) ? 1 : 0));
    check_eq("digits", dut_digits(), to_digits((m_state == 3) ? m_lap : m_live));
  endtask

  task automatic press_ss(input bit tk);
    cycle(1'b0, 1'b1, 1'b0, tk);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_lr();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bit ss_lvl, lr_lvl;
    // Reset with start/stop held through release: no transition.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("reset_state", 32'(state), 32'(0));
    check_eq("reset_en", 32'(count_en), 32'(0));
    check_eq("reset_digits", dut_digits(), 32'h0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Start and count.
    press_ss(1'b0);
    ticks(75);
    check_eq("run_state", 32'(state), 32'(1));
    check_eq("run_0115", dut_digits(), 32'h0115);
    press_ss(1'b0);
    ticks(3);
    check_eq("pause_state", 32'(state), 32'(2));
    check_eq("pause_hold", dut_digits(), 32'h0115);
    press_lr();
    check_eq("clear_0115", dut_digits(), 32'h0000);

    // Lap freeze.
    press_ss(1'b0);
    ticks(10);
    press_lr();
    ticks(5);
    check_eq("lap_state", 32'(state), 32'(3));
    check_eq("lap_frozen", dut_digits(), 32'h0010);
    press_lr();
    check_eq("lap_release_state", 32'(state), 32'(1));
    check_eq("lap_release_live", dut_digits(), 32'h0015);

    // Clear from pause at 00:07.
    press_ss(1'b0);
    press_lr();
    press_ss(1'b0);
    ticks(7);
    check_eq("run_0007", dut_digits(), 32'h0007);
    press_ss(1'b0);
    press_lr();
    check_eq("clear_state", 32'(state), 32'(0));
    check_eq("clear_digits", dut_digits(), 32'h0000);
    press_lr();
    check_eq("idle_lr_state", 32'(state), 32'(0));
    check_eq("idle_lr_digits", dut_digits(), 32'h0000);

    // Wrap at 59:59, then tick on the RUN->PAUSE edge.
    press_ss(1'b0);
    ticks(3599);
    check_eq("at_5959", dut_digits(), 32'h5959);
    ticks(1);
    check_eq("wrap_digits", dut_digits(), 32'h0000);
    check_eq("wrap_state", 32'(state), 32'(1));
    press_ss(1'b1);
    check_eq("stop_tick_state", 32'(state), 32'(2));
    check_eq("stop_tick_digits", dut_digits(), 32'h0001);

    // Simultaneous presses in RUN: start/stop wins.
    press_ss(1'b0);
    ticks(3);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("simul_state", 32'(state), 32'(2));
    check_eq("simul_digits", dut_digits(), 32'h0004);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized phase.
    ss_lvl = 1'b0;
    lr_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) ss_lvl = ~ss_lvl;
      if ($urandom_range(0, 6) == 0) lr_lvl = ~lr_lvl;
      cycle(($urandom_range(0, 399) == 0), ss_lvl, lr_lvl, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
